// File: rtl/ahb_pkg.sv
// Shared AHB encodings and slave FSM state type.
// AHB_SLAVE_MEM_WAIT_EN adds the read wait state StRwait.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWrite = 3'd1,
    StRead  = 3'd2,
    StErr   = 3'd3
`ifdef AHB_SLAVE_MEM_WAIT_EN
    ,
    StRwait = 3'd4
`endif
  } state_e;

  // Only NONSEQ and SEQ carry a real transfer.
  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_sram.sv
// Storage array: synchronous write, combinational read.
module ahb_sram #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: FSM, error response, write forwarding, optional read waits.
// AHB_SLAVE_MEM_WAIT_EN enables WAIT_CYC read wait states via StRwait and a down-counter.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic              HWRITE,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HBURST,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int unsigned     AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

  state_e            r_state;
  logic [AW-1:0]     r_addr;
  logic [DATA_W-1:0] r_hrdata;
  logic              r_hreadyout;
  logic              r_hresp;

  logic              w_accept;
  logic              w_oor;
  logic              w_we;
  logic              w_fwd;
  logic [AW-1:0]     w_raddr;
  logic [DATA_W-1:0] w_mem_rdata;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_unused;

`ifdef AHB_SLAVE_MEM_WAIT_EN
  localparam int unsigned CNT_W = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
  logic [CNT_W-1:0] r_cnt;
  assign w_raddr = (r_state == StRwait) ? r_addr : HADDR[AW-1:0];
`else
  assign w_raddr = HADDR[AW-1:0];
`endif

  assign w_unused = ^{HBURST, 32'(WAIT_CYC)};

  assign w_accept = HSEL && HREADY && r_hreadyout && is_active(HTRANS);
  assign w_oor    = ({1'b0, HADDR} >= LP_DEPTH);
  assign w_we     = (r_state == StWrite);
  // A write in its data phase lands at this edge; a read sampling the same word must see it now.
  assign w_fwd     = w_we && (r_addr == HADDR[AW-1:0]);
  assign w_rd_word = w_fwd ? HWDATA : w_mem_rdata;

  ahb_sram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_sram (
    .i_clk   (HCLK),
    .i_we    (w_we),
    .i_waddr (r_addr),
    .i_wdata (HWDATA),
    .i_raddr (w_raddr),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_hrdata    <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
`ifdef AHB_SLAVE_MEM_WAIT_EN
      r_cnt       <= '0;
`endif
    end else if ((r_state == StErr) && !r_hreadyout) begin
      r_hreadyout <= 1'b1;
`ifdef AHB_SLAVE_MEM_WAIT_EN
    end else if (r_state == StRwait) begin
      if (r_cnt == CNT_W'(1)) begin
        r_state     <= StRead;
        r_hreadyout <= 1'b1;
        r_hrdata    <= w_rd_word;
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
`endif
    end else if (w_accept) begin
      r_addr <= HADDR[AW-1:0];
      if (w_oor) begin
        r_state     <= StErr;
        r_hreadyout <= 1'b0;
        r_hresp     <= HRESP_ERROR;
      end else if (HWRITE) begin
        r_state     <= StWrite;
        r_hreadyout <= 1'b1;
        r_hresp     <= HRESP_OKAY;
      end else begin
`ifdef AHB_SLAVE_MEM_WAIT_EN
        if (WAIT_CYC != 0) begin
          r_state     <= StRwait;
          r_hreadyout <= 1'b0;
          r_hresp     <= HRESP_OKAY;
          r_cnt       <= CNT_W'(WAIT_CYC);
        end else
`endif
        begin
          r_state     <= StRead;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_OKAY;
          r_hrdata    <= w_rd_word;
        end
      end
    end else begin
      r_state     <= StIdle;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
    end
  end

  assign HRDATA    = r_hrdata;
  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;

endmodule
